// File: rtl/cpu_pkg.sv
// Shared CPU register-file types and constants.
// Pure declarations: no logic, no latency.
// No flow control of its own; users carry valid/ready alongside.
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bundle of producer, decode and reg_file write-port signals around reg_wb_ctrl.
// Pure wiring, zero latency.
// lsu_ready / issue_ready are the only backpressure signals; ALU has none.
interface reg_wb_ctrl_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;

    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rs1_fwd_valid;
    logic [DATA_W-1:0] rs1_fwd_data;
    logic              rs2_fwd_valid;
    logic [DATA_W-1:0] rs2_fwd_data;

    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;

    // master: the pipeline side driving producers and decode lookups
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        output rs1, rs2,
        input  lsu_ready, issue_ready,
        input  rs1_busy, rs2_busy,
        input  rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
        input  rd, write_data, write_enable
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        input  rs1, rs2,
        output lsu_ready, issue_ready,
        output rs1_busy, rs2_busy,
        output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
        output rd, write_data, write_enable
    );

endinterface

// File: rtl/wb_fifo.sv
// Writeback queue holding long-latency results (rd, data) in arrival order.
// Latency: head valid the cycle after push; no push-to-head bypass.
// Backpressure: full asserted at DEPTH entries; push while full / pop while empty are ignored.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_file write-port arbiter (ALU first, queued LSU results otherwise) plus busy scoreboard/forwarding; optional WB_STATS_EN counters.
// Latency: ALU result written same cycle; queued result no earlier than the cycle after enqueue.
// Backpressure: lsu_ready = !full (ignores same-cycle dequeue); issue_ready drops on WAW against a pending rd.
module reg_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    reg_wb_ctrl_if.slave bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0]  stat_alu_wr,
    output logic [31:0]  stat_q_wr,
    output logic [31:0]  stat_lsu_stall
`endif
);

    localparam int NREG = 1 << ADDR_W;

    cpu_pkg::wb_entry_t push_entry;
    cpu_pkg::wb_entry_t head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic               src_vld;
    logic [ADDR_W-1:0]  wb_rd;
    logic [DATA_W-1:0]  wb_data;
    logic               wb_en;

    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_nxt;
    logic               issue_set;

    assign push_entry.rd   = bus.lsu_rd;
    assign push_entry.data = bus.lsu_data;

    assign bus.lsu_ready = rst || !full;
    assign push          = !rst && bus.lsu_valid && !full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // ALU has strict priority; a starved queue simply waits for an idle ALU cycle
    always_comb begin
        src_vld = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        pop     = 1'b0;
        if (!rst) begin
            if (bus.alu_valid) begin
                src_vld = 1'b1;
                wb_rd   = bus.alu_rd;
                wb_data = bus.alu_data;
            end else if (!empty) begin
                src_vld = 1'b1;
                wb_rd   = head.rd;
                wb_data = head.data;
                pop     = 1'b1;
            end
        end
    end

    assign wb_en            = src_vld && (wb_rd != cpu_pkg::REG_ZERO);
    assign bus.rd           = wb_rd;
    assign bus.write_data   = wb_data;
    assign bus.write_enable = wb_en;

    assign bus.rs1_fwd_valid = wb_en && (wb_rd == bus.rs1) && (bus.rs1 != cpu_pkg::REG_ZERO);
    assign bus.rs2_fwd_valid = wb_en && (wb_rd == bus.rs2) && (bus.rs2 != cpu_pkg::REG_ZERO);
    assign bus.rs1_fwd_data  = bus.rs1_fwd_valid ? wb_data : '0;
    assign bus.rs2_fwd_data  = bus.rs2_fwd_valid ? wb_data : '0;

    // busy is gated by rst because the register only clears at the end of the reset cycle
    assign bus.rs1_busy    = !rst && busy[bus.rs1] && !bus.rs1_fwd_valid;
    assign bus.rs2_busy    = !rst && busy[bus.rs2] && !bus.rs2_fwd_valid;
    assign bus.issue_ready = rst || !busy[bus.issue_rd];

    assign issue_set = !rst && bus.issue_valid && bus.issue_ready
                       && (bus.issue_rd != cpu_pkg::REG_ZERO);

    // Clear first, then set, so a new issue to the retiring rd stays pending
    always_comb begin
        busy_nxt = busy;
        if (pop && (head.rd != cpu_pkg::REG_ZERO)) busy_nxt[head.rd] = 1'b0;
        if (issue_set) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_alu_wr    <= '0;
            stat_q_wr      <= '0;
            stat_lsu_stall <= '0;
        end else begin
            if (bus.alu_valid && wb_en)             stat_alu_wr    <= stat_alu_wr + 32'd1;
            if (pop)                                stat_q_wr      <= stat_q_wr + 32'd1;
            if (bus.lsu_valid && !bus.lsu_ready)    stat_lsu_stall <= stat_lsu_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scenario bench for reg_wb_ctrl: queued LSU results are predicted into a scoreboard queue
// on acceptance and popped when the write port shows a queue commit.
module tb_reg_wb_ctrl;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exq[$];

    always #5 clk = ~clk;

    reg_wb_ctrl_if bus ();

`ifdef WB_STATS_EN
    logic [31:0] stat_alu_wr, stat_q_wr, stat_lsu_stall;
`endif

    reg_wb_ctrl #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_STATS_EN
        ,
        .stat_alu_wr    (stat_alu_wr),
        .stat_q_wr      (stat_q_wr),
        .stat_lsu_stall (stat_lsu_stall)
`endif
    );

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        bus.rs1 = 0; bus.rs2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1234_5678; bus.rs1 = 5'd3;
        @(negedge clk);
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_alu_we got=%b exp=0", bus.write_enable); end
        n_cmp++; if (bus.rs1_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fwd got=%b exp=0", bus.rs1_fwd_valid); end
        tick();
        rst = 0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL idle_we[%0d] got=%b exp=0", i, bus.write_enable); end
            n_cmp++; if ({bus.rd, bus.write_data} !== 37'd0) begin n_bad++; $display("FAIL idle_wport[%0d] got=%h/%h exp=0/0", i, bus.rd, bus.write_data); end
            n_cmp++; if ({bus.lsu_ready, bus.issue_ready} !== 2'b11) begin n_bad++; $display("FAIL idle_ready[%0d] got=%b exp=11", i, {bus.lsu_ready, bus.issue_ready}); end
            n_cmp++; if ({bus.rs1_busy, bus.rs2_busy, bus.rs1_fwd_valid, bus.rs2_fwd_valid} !== 4'b0) begin
                n_bad++; $display("FAIL idle_hazard[%0d] got=%b exp=0000", i, {bus.rs1_busy, bus.rs2_busy, bus.rs1_fwd_valid, bus.rs2_fwd_valid});
            end
            tick();
        end
    endtask

    task automatic test_alu_fwd();
        idle_inputs();
        bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA5A5_A5A5;
        bus.rs1 = 5'd1; bus.rs2 = 5'd7;
        @(negedge clk);
        n_cmp++; if (bus.write_enable !== 1'b1) begin n_bad++; $display("FAIL alu_we got=%b exp=1", bus.write_enable); end
        n_cmp++; if (bus.rd !== 5'd1) begin n_bad++; $display("FAIL alu_rd got=%0d exp=1", bus.rd); end
        n_cmp++; if (bus.write_data !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL alu_data got=%h exp=a5a5a5a5", bus.write_data); end
        n_cmp++; if (bus.rs1_fwd_valid !== 1'b1) begin n_bad++; $display("FAIL alu_fwd1_v got=%b exp=1", bus.rs1_fwd_valid); end
        n_cmp++; if (bus.rs1_fwd_data !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL alu_fwd1_d got=%h exp=a5a5a5a5", bus.rs1_fwd_data); end
        n_cmp++; if ({bus.rs2_fwd_valid, bus.rs2_fwd_data} !== 33'd0) begin n_bad++; $display("FAIL alu_fwd2 got=%b/%h exp=0/0", bus.rs2_fwd_valid, bus.rs2_fwd_data); end
        tick();
        idle_inputs();
    endtask

    task automatic test_lsu_commit();
        exp_t e;
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd2; bus.rs2 = 5'd2;
        @(negedge clk);
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL issue1_ready got=%b exp=1", bus.issue_ready); end
        n_cmp++; if (bus.rs2_busy !== 1'b0) begin n_bad++; $display("FAIL issue1_busy got=%b exp=0", bus.rs2_busy); end
        tick();
        // second issue to rd 2 (must stall) and the LSU result arrive together
        bus.lsu_valid = 1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h5A5A_5A5A;
        @(negedge clk);
        n_cmp++; if (bus.rs2_busy !== 1'b1) begin n_bad++; $display("FAIL pend_busy got=%b exp=1", bus.rs2_busy); end
        n_cmp++; if (bus.issue_ready !== 1'b0) begin n_bad++; $display("FAIL waw_ready got=%b exp=0", bus.issue_ready); end
        n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_bad++; $display("FAIL enq_ready got=%b exp=1", bus.lsu_ready); end
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL no_passthru got=%b exp=0", bus.write_enable); end
        e.rd = 5'd2; e.data = 32'h5A5A_5A5A; exq.push_back(e);
        tick();
        bus.lsu_valid = 0; bus.issue_valid = 0;
        @(negedge clk);
        e = exq.pop_front();
        n_cmp++; if (bus.write_enable !== 1'b1) begin n_bad++; $display("FAIL commit_we got=%b exp=1", bus.write_enable); end
        n_cmp++; if ({bus.rd, bus.write_data} !== {e.rd, e.data}) begin n_bad++; $display("FAIL commit_wport got=%0d/%h exp=%0d/%h", bus.rd, bus.write_data, e.rd, e.data); end
        n_cmp++; if ({bus.rs2_fwd_valid, bus.rs2_busy} !== 2'b10) begin n_bad++; $display("FAIL commit_fwd got=%b exp=10", {bus.rs2_fwd_valid, bus.rs2_busy}); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.rs2_busy !== 1'b0) begin n_bad++; $display("FAIL cleared_busy got=%b exp=0", bus.rs2_busy); end
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL cleared_ready got=%b exp=1", bus.issue_ready); end
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL after_commit_we got=%b exp=0", bus.write_enable); end
        tick();
        idle_inputs();
    endtask

    task automatic test_alu_starve();
        int   accepted = 0;
        int   cyc = 0;
        logic ready_exp;
        exp_t e;
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(8 + i); bus.alu_data = 32'hA100_0000 + i;
            bus.lsu_valid = (accepted < 5); bus.lsu_rd = 5'(16 + accepted); bus.lsu_data = 32'hB000_0000 + accepted;
            @(negedge clk);
            ready_exp = (exq.size() < 4);
            n_cmp++; if ({bus.write_enable, bus.rd} !== {1'b1, 5'(8 + i)}) begin n_bad++; $display("FAIL starve_alu[%0d] got=%b/%0d exp=1/%0d", i, bus.write_enable, bus.rd, 8 + i); end
            n_cmp++; if (bus.lsu_ready !== ready_exp) begin n_bad++; $display("FAIL starve_ready[%0d] got=%b exp=%b", i, bus.lsu_ready, ready_exp); end
            if (bus.lsu_valid && ready_exp) begin
                e.rd = bus.lsu_rd; e.data = bus.lsu_data; exq.push_back(e); accepted++;
            end
            tick();
        end
        while ((exq.size() > 0 || accepted < 5) && cyc < 30) begin
            bus.alu_valid = cyc[0]; bus.alu_rd = 5'd9; bus.alu_data = 32'hC000_0000 + cyc;
            bus.lsu_valid = (accepted < 5); bus.lsu_rd = 5'(16 + accepted); bus.lsu_data = 32'hB000_0000 + accepted;
            @(negedge clk);
            ready_exp = (exq.size() < 4);
            if (bus.alu_valid) begin
                n_cmp++; if ({bus.write_enable, bus.rd, bus.write_data} !== {1'b1, 5'd9, 32'hC000_0000 + cyc}) begin
                    n_bad++; $display("FAIL drain_alu[%0d] got=%b/%0d/%h exp=1/9/%h", cyc, bus.write_enable, bus.rd, bus.write_data, 32'hC000_0000 + cyc);
                end
            end else if (exq.size() > 0) begin
                e = exq.pop_front();
                n_cmp++; if ({bus.write_enable, bus.rd, bus.write_data} !== {1'b1, e.rd, e.data}) begin
                    n_bad++; $display("FAIL drain_q[%0d] got=%b/%0d/%h exp=1/%0d/%h", cyc, bus.write_enable, bus.rd, bus.write_data, e.rd, e.data);
                end
            end
            n_cmp++; if (bus.lsu_ready !== ready_exp) begin n_bad++; $display("FAIL drain_ready[%0d] got=%b exp=%b", cyc, bus.lsu_ready, ready_exp); end
            if (bus.lsu_valid && ready_exp) begin
                e.rd = bus.lsu_rd; e.data = bus.lsu_data; exq.push_back(e); accepted++;
            end
            tick();
            cyc++;
        end
        n_cmp++; if (exq.size() != 0 || accepted != 5) begin n_bad++; $display("FAIL drain_timeout left=%0d accepted=%0d exp=0/5", exq.size(), accepted); end
        exq.delete();
        idle_inputs();
    endtask

    task automatic test_reg_zero();
        exp_t e;
        idle_inputs();
        bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h1234_5678;
        bus.rs1 = 5'd0;
        @(negedge clk);
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL z_alu_we got=%b exp=0", bus.write_enable); end
        n_cmp++; if ({bus.rs1_fwd_valid, bus.rs1_busy} !== 2'b00) begin n_bad++; $display("FAIL z_alu_fwd got=%b exp=00", {bus.rs1_fwd_valid, bus.rs1_busy}); end
        e.rd = 5'd0; e.data = 32'h1234_5678; exq.push_back(e);
        tick();
        bus.alu_valid = 0;
        bus.lsu_valid = 1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'hC3C3_C3C3;
        @(negedge clk);
        e = exq.pop_front();
        n_cmp++; if ({bus.write_enable, bus.rd} !== {1'b0, e.rd}) begin n_bad++; $display("FAIL z_q_we got=%b/%0d exp=0/%0d", bus.write_enable, bus.rd, e.rd); end
        n_cmp++; if (bus.rs1_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL z_q_fwd got=%b exp=0", bus.rs1_fwd_valid); end
        e.rd = 5'd3; e.data = 32'hC3C3_C3C3; exq.push_back(e);
        tick();
        bus.lsu_valid = 0;
        @(negedge clk);
        e = exq.pop_front();
        n_cmp++; if ({bus.write_enable, bus.rd, bus.write_data} !== {1'b1, e.rd, e.data}) begin
            n_bad++; $display("FAIL z_consumed got=%b/%0d/%h exp=1/%0d/%h", bus.write_enable, bus.rd, bus.write_data, e.rd, e.data);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_rd = 5'd5;
        @(negedge clk);
        n_cmp++; if (bus.issue_ready !== 1'b1) begin n_bad++; $display("FAIL mid_issue got=%b exp=1", bus.issue_ready); end
        tick();
        bus.issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'hD000_0000 + i;
            bus.lsu_valid = 1; bus.lsu_rd = 5'd5; bus.lsu_data = 32'hE000_0000 + i;
            tick();
        end
        bus.lsu_valid = 0; bus.rs1 = 5'd5; bus.issue_rd = 5'd5;
        @(negedge clk);
        n_cmp++; if ({bus.rs1_busy, bus.issue_ready} !== 2'b10) begin n_bad++; $display("FAIL mid_pending got=%b exp=10", {bus.rs1_busy, bus.issue_ready}); end
        tick();
        rst = 1;
        @(negedge clk);
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we got=%b exp=0", bus.write_enable); end
        n_cmp++; if ({bus.lsu_ready, bus.issue_ready, bus.rs1_busy} !== 3'b110) begin
            n_bad++; $display("FAIL mid_rst_flags got=%b exp=110", {bus.lsu_ready, bus.issue_ready, bus.rs1_busy});
        end
        tick();
        rst = 0;
        bus.alu_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL post_rst_we[%0d] got=%b exp=0", i, bus.write_enable); end
            n_cmp++; if ({bus.rs1_busy, bus.issue_ready} !== 2'b01) begin n_bad++; $display("FAIL post_rst_busy[%0d] got=%b exp=01", i, {bus.rs1_busy, bus.issue_ready}); end
`ifdef WB_STATS_EN
            n_cmp++; if ({stat_alu_wr, stat_q_wr, stat_lsu_stall} !== 96'd0) begin
                n_bad++; $display("FAIL post_rst_stats[%0d] got=%0d/%0d/%0d exp=0/0/0", i, stat_alu_wr, stat_q_wr, stat_lsu_stall);
            end
`endif
            tick();
        end
        exq.delete();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_alu_fwd();
        test_lsu_commit();
        test_alu_starve();
        test_reg_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
